// File: rtl/tone_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tone_decoder
// Description : Measures the half-period of a speaker-style square wave,
//               classifies it against a table of twelve note half-periods and
//               reports the locked note, plus a one-cycle summary (note code
//               and lock length) whenever a locked note ends.
// Revision    : 1.0 - initial release
// ============================================================================
module tone_decoder #(
  parameter logic [27:0] NOTE0   = 28'd0,
  parameter logic [27:0] NOTE1   = 28'd0,
  parameter logic [27:0] NOTE2   = 28'd0,
  parameter logic [27:0] NOTE3   = 28'd0,
  parameter logic [27:0] NOTE4   = 28'd0,
  parameter logic [27:0] NOTE5   = 28'd0,
  parameter logic [27:0] NOTE6   = 28'd0,
  parameter logic [27:0] NOTE7   = 28'd0,
  parameter logic [27:0] NOTE8   = 28'd0,
  parameter logic [27:0] NOTE9   = 28'd0,
  parameter logic [27:0] NOTE10  = 28'd0,
  parameter logic [27:0] NOTE11  = 28'd0,
  parameter logic [27:0] TOL     = 28'd2,
  parameter logic [27:0] REST_TO = 28'd1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        tone_in,
  output logic [3:0]  note,
  output logic        locked,
  output logic [27:0] half_period,
  output logic        done,
  output logic [3:0]  done_note,
  output logic [27:0] done_len
);

  typedef enum logic [1:0] {
    SILENT = 2'd0,
    ACQ    = 2'd1,
    LOCK   = 2'd2
  } state_t;

  localparam logic [3:0]  CODE_NONE = 4'hE;  // measured period matches no note
  localparam logic [3:0]  NOTE_OFF  = 4'hF;  // silent / not locked
  localparam logic [27:0] CNT_MAX   = 28'hFFFFFFF;

  // Note table packed so entry i sits at bits [i*28 +: 28].
  localparam logic [12*28-1:0] NOTE_TBL = {NOTE11, NOTE10, NOTE9, NOTE8,
                                           NOTE7,  NOTE6,  NOTE5, NOTE4,
                                           NOTE3,  NOTE2,  NOTE1, NOTE0};

  // Registered state
  state_t      state_q,       state_d;
  logic        sync1_q,       sync1_d;
  logic        sync2_q,       sync2_d;
  logic        dly_q,         dly_d;
  logic [27:0] per_cnt_q,     per_cnt_d;
  logic [27:0] dur_cnt_q,     dur_cnt_d;
  logic [27:0] half_period_q, half_period_d;
  logic        meas_ok_q,     meas_ok_d;
  logic [3:0]  cand_q,        cand_d;
  logic [3:0]  pend_q,        pend_d;
  logic        pend_valid_q,  pend_valid_d;
  logic [3:0]  note_q,        note_d;
  logic        done_q,        done_d;
  logic [3:0]  done_note_q,   done_note_d;
  logic [27:0] done_len_q,    done_len_d;

  // Combinational helpers
  logic        tone_edge;
  logic        timeout;
  logic [3:0]  code;

  // Unsigned absolute difference; never wraps.
  function automatic logic [27:0] abs_diff(input logic [27:0] a,
                                           input logic [27:0] b);
    abs_diff = (a >= b) ? (a - b) : (b - a);
  endfunction

  // Synchroniser chain and edge detect; the edge is seen 3 clk after a toggle.
  always_comb begin
    sync1_d   = tone_in;
    sync2_d   = sync1_q;
    dly_d     = sync2_q;
    tone_edge = sync2_q ^ dly_q;
  end

  // Classify the current period: lowest matching table index wins.
  always_comb begin
    code = CODE_NONE;
    for (int i = 11; i >= 0; i--) begin
      if (abs_diff(per_cnt_q, NOTE_TBL[i*28 +: 28]) <= TOL) begin
        code = i[3:0];
      end
    end
    timeout = (per_cnt_q >= REST_TO) && !tone_edge;
  end

  // Next-state logic: enable clear, period measurement and the SILENT/ACQ/LOCK FSM.
  always_comb begin
    state_d       = state_q;
    per_cnt_d     = per_cnt_q;
    dur_cnt_d     = dur_cnt_q;
    half_period_d = half_period_q;
    meas_ok_d     = meas_ok_q;
    cand_d        = cand_q;
    pend_d        = pend_q;
    pend_valid_d  = pend_valid_q;
    note_d        = note_q;
    done_d        = 1'b0;
    done_note_d   = done_note_q;
    done_len_d    = done_len_q;

    if (!en) begin
      // Disabled: return to silence quietly, no done summary.
      state_d      = SILENT;
      per_cnt_d    = 28'd0;
      dur_cnt_d    = 28'd0;
      cand_d       = CODE_NONE;
      pend_valid_d = 1'b0;
      meas_ok_d    = 1'b0;
      note_d       = NOTE_OFF;
    end else begin
      per_cnt_d = tone_edge ? 28'd1
                : (per_cnt_q == CNT_MAX) ? CNT_MAX : per_cnt_q + 28'd1;

      if (tone_edge && meas_ok_q) begin
        half_period_d = per_cnt_q;
      end

      case (state_q)
        SILENT: begin
          meas_ok_d = 1'b0;
          note_d    = NOTE_OFF;
          if (tone_edge) begin
            // First edge only starts the measurement; the candidate is
            // invalidated so a lock always needs two agreeing periods.
            state_d   = ACQ;
            meas_ok_d = 1'b1;
            cand_d    = CODE_NONE;
          end
        end

        ACQ: begin
          if (tone_edge && meas_ok_q) begin
            if ((code == cand_q) && (code != CODE_NONE)) begin
              state_d      = LOCK;
              note_d       = code;
              dur_cnt_d    = 28'd1;
              pend_valid_d = 1'b0;
            end else begin
              cand_d = code;
            end
          end else if (timeout) begin
            state_d   = SILENT;
            meas_ok_d = 1'b0;
          end
        end

        LOCK: begin
          dur_cnt_d = (dur_cnt_q == CNT_MAX) ? CNT_MAX : dur_cnt_q + 28'd1;
          if (tone_edge) begin
            if (code == note_q) begin
              pend_valid_d = 1'b0;
            end else if (!pend_valid_q || (code != pend_q)) begin
              pend_d       = code;
              pend_valid_d = 1'b1;
            end else begin
              // Second consecutive agreeing period of a new code: note ends.
              done_d       = 1'b1;
              done_note_d  = note_q;
              done_len_d   = dur_cnt_q;
              pend_valid_d = 1'b0;
              if (pend_q != CODE_NONE) begin
                note_d    = pend_q;
                dur_cnt_d = 28'd1;
              end else begin
                state_d = ACQ;
                cand_d  = CODE_NONE;
                note_d  = NOTE_OFF;
              end
            end
          end else if (timeout) begin
            done_d       = 1'b1;
            done_note_d  = note_q;
            done_len_d   = dur_cnt_q;
            state_d      = SILENT;
            note_d       = NOTE_OFF;
            meas_ok_d    = 1'b0;
            pend_valid_d = 1'b0;
          end
        end

        default: begin
          state_d = SILENT;
          note_d  = NOTE_OFF;
        end
      endcase
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= SILENT;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      dly_q         <= 1'b0;
      per_cnt_q     <= 28'd0;
      dur_cnt_q     <= 28'd0;
      half_period_q <= 28'd0;
      meas_ok_q     <= 1'b0;
      cand_q        <= CODE_NONE;
      pend_q        <= CODE_NONE;
      pend_valid_q  <= 1'b0;
      note_q        <= NOTE_OFF;
      done_q        <= 1'b0;
      done_note_q   <= NOTE_OFF;
      done_len_q    <= 28'd0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      dly_q         <= dly_d;
      per_cnt_q     <= per_cnt_d;
      dur_cnt_q     <= dur_cnt_d;
      half_period_q <= half_period_d;
      meas_ok_q     <= meas_ok_d;
      cand_q        <= cand_d;
      pend_q        <= pend_d;
      pend_valid_q  <= pend_valid_d;
      note_q        <= note_d;
      done_q        <= done_d;
      done_note_q   <= done_note_d;
      done_len_q    <= done_len_d;
    end
  end

  // Output drive.
  always_comb begin
    note        = note_q;
    locked      = (state_q == LOCK);
    half_period = half_period_q;
    done        = done_q;
    done_note   = done_note_q;
    done_len    = done_len_q;
  end

endmodule
`default_nettype wire

// File: doc/tone_decoder.md
TONE_DECODER -- requirements
Module: tone_decoder

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NOTE0..NOTE11, 28'd0: expected half-period in clk cycles for note codes 0..11.
- TOL, 28'd2: match tolerance in clk cycles.
- REST_TO, 28'd1000000: clocks without an edge that mean silence.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, input, 1: single clock; all logic on posedge.
- reset, input, 1: asynchronous, active-high reset.
- en, input, 1: decoder enable; low means synchronous clear.
- tone_in, input, 1: asynchronous square wave, speaker-style, one toggle per half-period.
- note, output, 4: locked note code 0..11; 4'hF means silent or not locked.
- locked, output, 1: high while in state LOCK.
- half_period, output, 28: last measured half-period.
- done, output, 1: one-cycle pulse when a locked note ends.
- done_note, output, 4: code of the note that ended; valid with done.
- done_len, output, 28: clock count that note was locked; valid with done.

Function
REQ-003 tone_in SHALL pass through a 2-flop synchroniser plus one delay flop. edge = sync XOR delayed. Latency from tone_in toggle to edge is 3 clk.
REQ-004 per_cnt (28-bit) SHALL load 1 on an edge cycle, otherwise increment, saturating at 28'hFFFFFFF.
REQ-005 On each edge with meas_ok=1, half_period SHALL load per_cnt. meas_ok is cleared in SILENT and set by the first edge after SILENT.
REQ-006 Classification SHALL give code = lowest i with |per_cnt - NOTEi| <= TOL. If no entry matches, code = 4'hE. The subtraction SHALL be unsigned 28-bit absolute difference with no wrap.
REQ-007 timeout SHALL be (per_cnt >= REST_TO) and no edge in that cycle.
REQ-008 The FSM SHALL have exactly three states: SILENT, ACQ, LOCK.
REQ-009 SILENT: on an edge, go to ACQ and set meas_ok; no classification is made.
REQ-010 ACQ:
- On an edge with meas_ok, classify.
- If code = cand and code != 4'hE: go to LOCK, note <= code, dur_cnt <= 1.
- Otherwise cand <= code.
- On timeout: go to SILENT.
REQ-011 LOCK:
- dur_cnt increments every clk, saturating.
- On an edge, a code equal to note clears pend_valid.
- A code different from note and different from pend (or pend_valid=0) sets pend <= code, pend_valid <= 1.
- A code equal to a valid pend ends the note:
  - done=1, done_note=note, done_len=dur_cnt;
  - if pend != 4'hE: note <= pend, dur_cnt <= 1, stay in LOCK;
  - else: go to ACQ with cand=4'hE, note <= 4'hF.
REQ-012 LOCK timeout SHALL pulse done with done_note=note and done_len=dur_cnt, then go to SILENT with note <= 4'hF.
REQ-013 done SHALL be high for exactly one clk. done_note and done_len SHALL hold until the next done.
REQ-014 locked SHALL equal (state == LOCK). note SHALL be 4'hF whenever state != LOCK.
REQ-015 If en is low, the following SHALL occur in the next cycle:
- state = SILENT; per_cnt, dur_cnt, cand, pend_valid and meas_ok cleared.
- note = 4'hF; done = 0.
- half_period, done_note and done_len hold their values.
- No done pulse is produced, even when leaving LOCK.
REQ-016 An edge and a timeout SHALL never coincide, because an edge blocks timeout. Edge handling takes precedence over en=1 logic only. en=0 overrides everything except reset.

Reset
REQ-017 Asserting reset SHALL immediately force:
- state SILENT; note 4'hF; locked 0; done 0;
- done_note 4'hF; done_len 0; half_period 0;
- all counters 0; synchroniser flops 0.
REQ-018 Reset asserted mid-LOCK SHALL produce no done pulse. After release, operation SHALL restart from SILENT.

Verification
Bench parameters: NOTE0=10, NOTE1=20, NOTE2=40, others 28'hFFFFFFF, TOL=1, REST_TO=100.
REQ-019 Lock: en=1, tone_in toggles every 20 clk -> locked rises after the 3rd edge, note=1, half_period=20.
REQ-020 Change: locked on note 1, then switch to toggling every 10 clk -> after two matching edges, done=1 for 1 clk, done_note=1, done_len = lock duration, note=0.
REQ-021 Tolerance: half-periods alternating 39/41 -> note=2 steady. A single 30-clk half-period -> no done and no note change.
REQ-022 Silence: stop toggling while locked -> done pulses REST_TO clk after the last edge, note=4'hF, locked=0.
REQ-023 Unknown: toggling every 70 clk -> stays in ACQ, note=4'hF, locked=0, no done.
REQ-024 Disable/reset: en=0 while locked -> note=4'hF next clk, no done. reset mid-LOCK -> all outputs at their REQ-017 values.
